// File: rtl/usb_asp_spi_master.sv
// usb_asp_spi_master
// Byte-stream SPI master (mode 0, MSB first) behind the USB ASP control
// endpoint. OUT-stage bytes are shifted onto the SPI pins; every byte received
// on MISO is handed back as a one-cycle rx_valid pulse for the IN buffer.
//
// Ports:
//   clk, reset         system clock, synchronous active-low reset
//   tx_valid/ready     byte handshake; tx_data byte, tx_last ends the CS frame
//   abort              drop the current frame (no effect while idle)
//   rx_valid/rx_data   received byte, pulse with no backpressure
//   busy               high whenever the master is not idle
//   spi_sck/mosi/miso/cs_n  SPI pins, sck idles low, cs_n active low
//
// Build option: define USB_ASP_SPI_LOOPBACK_EN to sample spi_mosi instead of
// spi_miso (internal loopback, pin timing unchanged).
//
// state     | meaning
// IDLE      | cs_n high, waiting for the first byte of a frame
// CS_SETUP  | cs_n low, CLK_DIV cycles before the first sck edge
// SHIFT     | 8 bits, each CLK_DIV cycles sck low then CLK_DIV high
// BYTE_DONE | byte complete, rx_valid on entry; waits for next byte or ends
// CS_HOLD   | CLK_DIV cycles of cs_n low after the last byte

module usb_asp_spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       abort,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, BYTE_DONE, CS_HOLD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       last_q, last_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;

  logic       div_wrap;
  logic       accept;
  logic       sample_bit;
  logic [2:0] bit_dn;

`ifdef USB_ASP_SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign sample_bit  = mosi_q;
`else
  assign sample_bit  = spi_miso;
`endif

  assign div_wrap = (div_q == DIV_LAST);
  assign bit_dn   = bit_q - 3'd1;
  // tx_ready is combinational from state so a byte can be taken in the very
  // first BYTE_DONE cycle, giving the 16*CLK_DIV+1 back-to-back period.
  assign tx_ready = reset & ((state_q == IDLE) | ((state_q == BYTE_DONE) & ~last_q));
  assign accept   = tx_valid & tx_ready;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    last_d     = last_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;

    if (abort && (state_q != IDLE)) begin
      // abort overrides everything, including a byte offered in BYTE_DONE
      state_d = IDLE;
      sck_d   = 1'b0;
      cs_n_d  = 1'b1;
      div_d   = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tx_sh_d = tx_data;
            last_d  = tx_last;
            cs_n_d  = 1'b0;
            div_d   = 8'd0;
            state_d = CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (div_wrap) begin
            div_d   = 8'd0;
            bit_d   = 3'd7;
            mosi_d  = tx_sh_q[7];
            state_d = SHIFT;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        SHIFT: begin
          if (!div_wrap) begin
            div_d = div_q + 8'd1;
          end else begin
            div_d = 8'd0;
            if (!sck_q) begin
              sck_d   = 1'b1;
              rx_sh_d = {rx_sh_q[6:0], sample_bit};
            end else begin
              sck_d = 1'b0;
              if (bit_q == 3'd0) begin
                state_d    = BYTE_DONE;
                rx_valid_d = 1'b1;
                rx_data_d  = rx_sh_q;
              end else begin
                bit_d  = bit_dn;
                mosi_d = tx_sh_q[bit_dn];
              end
            end
          end
        end
        BYTE_DONE: begin
          if (last_q) begin
            div_d   = 8'd0;
            state_d = CS_HOLD;
          end else if (accept) begin
            tx_sh_d = tx_data;
            last_d  = tx_last;
            bit_d   = 3'd7;
            mosi_d  = tx_data[7];
            div_d   = 8'd0;
            state_d = SHIFT;
          end
        end
        CS_HOLD: begin
          if (div_wrap) begin
            div_d   = 8'd0;
            cs_n_d  = 1'b1;
            state_d = IDLE;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_q      <= 8'd0;
      bit_q      <= 3'd0;
      tx_sh_q    <= 8'd0;
      last_q     <= 1'b0;
      rx_sh_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      last_q     <= last_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = (state_q != IDLE);
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_usb_asp_spi_master.sv
// Self-checking bench for usb_asp_spi_master: directed frames from the test
// plan plus randomized frames, compared against timing/data expectations
// derived arithmetically from CLK_DIV and the bytes sent.
module tb_usb_asp_spi_master;
  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'd0;
  logic       tx_last = 1'b0;
  logic       abort = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs_n;

  usb_asp_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last), .abort(abort), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // pin monitor, sampled on the falling clock edge
  int         rise_total = 0;
  int         rise_cyc_q[$];
  logic       mosi_bits[$];
  int         cs_fall_q[$];
  int         cs_rise_q[$];
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];
  logic       prev_sck = 1'b0;
  logic       prev_cs = 1'b1;

  always @(negedge clk) begin
    if (spi_sck && !prev_sck) begin
      rise_total++;
      rise_cyc_q.push_back(cyc);
      mosi_bits.push_back(spi_mosi);
    end
    if (!spi_cs_n && prev_cs) cs_fall_q.push_back(cyc);
    if (spi_cs_n && !prev_cs) cs_rise_q.push_back(cyc);
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rx_cyc_q.push_back(cyc);
    end
    prev_sck = spi_sck;
    prev_cs  = spi_cs_n;
  end

  // target model: presents MSB-first bits of miso_b[], one per sck rise
  logic [7:0] miso_b[8];
  logic [7:0] tx_b[8];
  int         gap_b[8];
  int         rise_base = 0;
  int         rel;
  assign rel      = rise_total - rise_base;
  assign spi_miso = miso_b[rel[5:3]][3'd7 - rel[2:0]];

  task automatic present(input logic [7:0] d, input logic l, output int a);
    int t;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    t = 0;
    while (!tx_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("tx_ready_timeout", 0, 1);
    a = cyc;
    @(posedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("busy_timeout", 0, 1);
  endtask

  task automatic run_frame(input int n);
    int acc[8];
    int rb, rxb, cfb, crb, t;
    logic [7:0] exp_rx, got_tx;
    rise_base = rise_total;
    rb  = rise_cyc_q.size();
    rxb = rx_q.size();
    cfb = cs_fall_q.size();
    crb = cs_rise_q.size();
    for (int k = 0; k < n; k++) begin
      if (k > 0 && gap_b[k] > 0) begin
        @(negedge clk);
        tx_valid = 1'b0;
        t = 0;
        while (rx_q.size() < rxb + k && t < 400) begin
          @(negedge clk);
          t++;
        end
        if (t >= 400) check("rx_wait_timeout", 0, 1);
        repeat (gap_b[k] - 1) begin
          @(negedge clk);
          check("gap_sck_low", spi_sck, 0);
          check("gap_cs_low", spi_cs_n, 0);
        end
      end
      @(negedge clk);
      present(tx_b[k], (k == n - 1), acc[k]);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    wait_idle();
    check("tx_ready_idle", tx_ready, 1);
    repeat (3) @(negedge clk);

    check("rx_count", rx_q.size() - rxb, n);
    check("sck_rises", rise_cyc_q.size() - rb, 8 * n);
    check("cs_falls", cs_fall_q.size() - cfb, 1);
    check("cs_rises", cs_rise_q.size() - crb, 1);
    if (cs_fall_q.size() > cfb) check("cs_fall_cyc", cs_fall_q[cfb], acc[0] + 1);
    if (rise_cyc_q.size() > rb) check("first_rise_cyc", rise_cyc_q[rb], acc[0] + 1 + 2 * CLK_DIV);
    for (int k = 0; k < n; k++) begin
`ifdef USB_ASP_SPI_LOOPBACK_EN
      exp_rx = tx_b[k];
`else
      exp_rx = miso_b[k];
`endif
      if (rx_q.size() > rxb + k) begin
        check("rx_data", rx_q[rxb + k], exp_rx);
        if (k == 0) check("rx_cyc_first", rx_cyc_q[rxb], acc[0] + 1 + CLK_DIV + 16 * CLK_DIV);
        else        check("rx_cyc_next", rx_cyc_q[rxb + k], acc[k] + 16 * CLK_DIV + 1);
      end
      if (mosi_bits.size() >= rb + 8 * (k + 1)) begin
        got_tx = 8'd0;
        for (int b = 0; b < 8; b++) got_tx = {got_tx[6:0], mosi_bits[rb + 8 * k + b]};
        check("mosi_byte", got_tx, tx_b[k]);
      end
    end
    if (rx_q.size() >= rxb + n && n > 0 && cs_rise_q.size() > crb)
      check("cs_rise_cyc", cs_rise_q[crb], rx_cyc_q[rxb + n - 1] + 1 + CLK_DIV);
  endtask

  initial begin
    int a, rx0, rb, t, n;
    for (int i = 0; i < 8; i++) begin
      miso_b[i] = 8'd0; tx_b[i] = 8'd0; gap_b[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_tx_ready", tx_ready, 1);

    // abort while idle is ignored
    abort = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_cs", spi_cs_n, 1);
    abort = 1'b0;

    // single byte 0xA5, target returns 0x3C
    tx_b[0] = 8'hA5; miso_b[0] = 8'h3C;
    run_frame(1);

    // three-byte burst, tx_valid held high
    tx_b[0] = 8'h9F; tx_b[1] = 8'h00; tx_b[2] = 8'h00;
    miso_b[0] = 8'h11; miso_b[1] = 8'hC3; miso_b[2] = 8'h7E;
    run_frame(3);

    // second byte offered 10 cycles after the first rx_valid
    tx_b[0] = 8'h06; tx_b[1] = 8'hD8; miso_b[0] = 8'hE1; miso_b[1] = 8'h2B;
    gap_b[1] = 10;
    run_frame(2);
    gap_b[1] = 0;

    // abort after the 4th sck rise
    rx0 = rx_q.size();
    rise_base = rise_total;
    @(negedge clk);
    present(8'h5A, 1'b1, a);
    @(negedge clk);
    tx_valid = 1'b0;
    t = 0;
    while (rise_total - rise_base < 4 && t < 400) begin
      @(negedge clk);
      t++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sck", spi_sck, 0);
    check("abort_busy", busy, 0);
    repeat (40) @(negedge clk);
    check("abort_no_rx", rx_q.size() - rx0, 0);

    // abort together with a byte offered in BYTE_DONE: byte is dropped
    rx0 = rx_q.size();
    @(negedge clk);
    present(8'h33, 1'b0, a);
    @(negedge clk);
    tx_valid = 1'b0;
    t = 0;
    while (!rx_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    tx_valid = 1'b1; tx_data = 8'hCC; tx_last = 1'b1; abort = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; abort = 1'b0;
    check("bd_abort_busy", busy, 0);
    check("bd_abort_cs_n", spi_cs_n, 1);
    rb = rise_total;
    repeat (40) @(negedge clk);
    check("bd_abort_no_sck", rise_total - rb, 0);
    check("bd_abort_rx", rx_q.size() - rx0, 1);

    // reset pulse mid-frame
    rx0 = rx_q.size();
    @(negedge clk);
    present(8'h81, 1'b1, a);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_cs_n", spi_cs_n, 1);
    check("mid_rst_sck", spi_sck, 0);
    check("mid_rst_mosi", spi_mosi, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_ready", tx_ready, 0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_rst_no_rx", rx_q.size() - rx0, 0);
    tx_b[0] = 8'hA5; miso_b[0] = 8'h3C;
    run_frame(1);

`ifdef USB_ASP_SPI_LOOPBACK_EN
    tx_b[0] = 8'h12; tx_b[1] = 8'hFE; miso_b[0] = 8'h00; miso_b[1] = 8'h00;
    run_frame(2);
`endif

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) begin
        tx_b[k]   = 8'($urandom);
        miso_b[k] = 8'($urandom);
        gap_b[k]  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
      end
      run_frame(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
